// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply-controller state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ADDSUB = 2'd0;
  localparam logic [1:0] ALU_OP_NAND   = 2'd1;
  localparam logic [1:0] ALU_OP_SLT    = 2'd2;
  localparam logic [1:0] ALU_OP_SHIFT  = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ADD  = 3'd1;
  localparam state_t S_SHL  = 3'd2;
  localparam state_t S_SHR  = 3'd3;
  localparam state_t S_DONE = 3'd4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 unsigned multiplier that borrows the shared ALU one operation per cycle.
// Produces the low half of the product and a sticky flag for accumulation wrap.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] PRODUCT,
  output logic             CARRY,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_SHAMT,
  output logic [1:0]       ALU_OP,
  output logic             ALU_SUB,
  output logic             ALU_ARI,
  output logic             ALU_LEF,
  input  logic [WIDTH-1:0] ALU_C,
  input  logic             ALU_ZERO
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [3:0]       iter_q, iter_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             carry_q, carry_d;

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      iter_q    <= '0;
      product_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      carry_q   <= carry_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    iter_d    = iter_q;
    carry_d   = carry_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          mcand_d  = A_IN;
          mplier_d = B_IN;
          acc_d    = '0;
          iter_d   = '0;
          carry_d  = 1'b0;
          if (B_IN == '0)  state_d = S_DONE;
          else if (B_IN[0]) state_d = S_ADD;
          else              state_d = S_SHL;
        end
      end
      S_ADD: begin
        acc_d   = ALU_C;
        carry_d = carry_q | (ALU_C < acc_q);
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = ALU_C;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = ALU_C;
        iter_d   = iter_q + 4'd1;
        if ((EARLY_EXIT && ALU_ZERO) || iter_q == 4'd15) state_d = S_DONE;
        else if (ALU_C[0])                              state_d = S_ADD;
        else                                            state_d = S_SHL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Latch the accumulator value that will be current in DONE (zero for a zero multiplier).
    if (state_d == S_DONE && state_q != S_DONE) product_d = acc_d;
  end

  always_comb begin
    ALU_A     = '0;
    ALU_B     = '0;
    ALU_SHAMT = 4'd0;
    ALU_OP    = ALU_OP_ADDSUB;
    ALU_SUB   = 1'b0;
    ALU_ARI   = 1'b0;
    ALU_LEF   = 1'b0;
    case (state_q)
      S_ADD: begin
        ALU_OP = ALU_OP_ADDSUB;
        ALU_A  = acc_q;
        ALU_B  = mcand_q;
      end
      S_SHL: begin
        ALU_OP    = ALU_OP_SHIFT;
        ALU_LEF   = 1'b1;
        ALU_SHAMT = 4'd1;
        ALU_A     = mcand_q;
      end
      S_SHR: begin
        ALU_OP    = ALU_OP_SHIFT;
        ALU_SHAMT = 4'd1;
        ALU_A     = mplier_q;
      end
      default: ;
    endcase
  end

  assign READY   = (state_q == S_IDLE);
  assign DONE    = (state_q == S_DONE);
  assign PRODUCT = product_q;
  assign CARRY   = carry_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Drives an early-exit and a full-length multiplier with shared stimulus, each wired to a
// behavioural ALU; results are scored against an arithmetic reference model.
module tb_alu_mul_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] p;
    logic        c;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        ready   [2];
  logic        done    [2];
  logic [15:0] product [2];
  logic        carry   [2];
  logic [15:0] alu_a   [2];
  logic [15:0] alu_b   [2];
  logic [3:0]  alu_sh  [2];
  logic [1:0]  alu_op  [2];
  logic        alu_sub [2];
  logic        alu_ari [2];
  logic        alu_lef [2];
  logic [15:0] alu_c   [2];
  logic        alu_z   [2];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_ee (
    .CLK(clk), .RST_N(rst_n), .START(start), .A_IN(a_in), .B_IN(b_in),
    .READY(ready[1]), .DONE(done[1]), .PRODUCT(product[1]), .CARRY(carry[1]),
    .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_SHAMT(alu_sh[1]), .ALU_OP(alu_op[1]),
    .ALU_SUB(alu_sub[1]), .ALU_ARI(alu_ari[1]), .ALU_LEF(alu_lef[1]),
    .ALU_C(alu_c[1]), .ALU_ZERO(alu_z[1])
  );

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_full (
    .CLK(clk), .RST_N(rst_n), .START(start), .A_IN(a_in), .B_IN(b_in),
    .READY(ready[0]), .DONE(done[0]), .PRODUCT(product[0]), .CARRY(carry[0]),
    .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_SHAMT(alu_sh[0]), .ALU_OP(alu_op[0]),
    .ALU_SUB(alu_sub[0]), .ALU_ARI(alu_ari[0]), .ALU_LEF(alu_lef[0]),
    .ALU_C(alu_c[0]), .ALU_ZERO(alu_z[0])
  );

  function automatic logic [16:0] alu_f(input logic [1:0] op, input logic sub, input logic ari,
                                        input logic lef, input logic [3:0] sh,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] c;
    case (op)
      ALU_OP_ADDSUB: c = sub ? a - b : a + b;
      ALU_OP_NAND:   c = ~(a & b);
      ALU_OP_SLT:    c = {15'd0, $signed(a) < $signed(b)};
      default:       c = lef ? (a << sh) : (ari ? 16'($signed(a) >>> sh) : (a >> sh));
    endcase
    return {c == 16'd0, c};
  endfunction

  assign {alu_z[0], alu_c[0]} = alu_f(alu_op[0], alu_sub[0], alu_ari[0], alu_lef[0], alu_sh[0], alu_a[0], alu_b[0]);
  assign {alu_z[1], alu_c[1]} = alu_f(alu_op[1], alu_sub[1], alu_ari[1], alu_lef[1], alu_sh[1], alu_a[1], alu_b[1]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: product by plain multiplication, wrap flag by summing shifted partial products,
  // latency from the bit pattern (3 cycles per set bit, 2 per clear bit, plus the DONE cycle).
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit early,
                                 input int unsigned edge_k);
    exp_t        e;
    int unsigned acc = 0;
    int unsigned term;
    int          n = 16;
    int unsigned lat = 1;
    e.p = 16'(32'(a) * 32'(b));
    e.c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        term = (32'(a) << i) & 32'hFFFF;
        if (acc + term > 32'hFFFF) e.c = 1'b1;
        acc = (acc + term) & 32'hFFFF;
      end
    end
    if (b != 16'd0) begin
      if (early) for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
      for (int i = 0; i < n; i++) lat += b[i] ? 3 : 2;
    end
    e.cyc = edge_k + lat;
    return e;
  endfunction

  function automatic bit sb_pop(input int k, output exp_t e);
    e = '0;
    if (k == 0) begin
      if (sb0.size() == 0) return 1'b0;
      e = sb0.pop_front();
    end else begin
      if (sb1.size() == 0) return 1'b0;
      e = sb1.pop_front();
    end
    return 1'b1;
  endfunction

  exp_t mon_e;
  bit   mon_ok;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && done[k]) begin
        mon_ok = sb_pop(k, mon_e);
        if (!mon_ok) check($sformatf("spurious_done[%0d]", k), 64'd1, 64'd0);
        else begin
          check($sformatf("product[%0d]", k), 64'(product[k]), 64'(mon_e.p));
          check($sformatf("carry[%0d]", k), 64'(carry[k]), 64'(mon_e.c));
          check($sformatf("done_cycle[%0d]", k), 64'(cyc), 64'(mon_e.cyc));
        end
        check($sformatf("alu_quiet_in_done[%0d]", k),
              64'({alu_a[k], alu_b[k], alu_sh[k], alu_op[k], alu_sub[k], alu_ari[k], alu_lef[k]}), 64'd0);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int w = 0;
    while (!(ready[0] && ready[1]) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    sb0.push_back(model(a, b, 1'b0, cyc));
    sb1.push_back(model(a, b, 1'b1, cyc));
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
  endtask

  task automatic check_idle_after_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_ready[%0d]", tag, k), 64'(ready[k]), 64'd1);
      check($sformatf("%s_done[%0d]", tag, k), 64'(done[k]), 64'd0);
      check($sformatf("%s_product[%0d]", tag, k), 64'(product[k]), 64'd0);
      check($sformatf("%s_carry[%0d]", tag, k), 64'(carry[k]), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          w;
    repeat (3) @(negedge clk);
    check_idle_after_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd3, 16'd5);
    issue(16'h1234, 16'h0000);
    issue(16'hFFFF, 16'hFFFF);
    issue(16'h8000, 16'h0002);

    // Starts arriving while busy must be dropped without disturbing the accepted operation.
    issue(16'd7, 16'd9);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      a_in  = 16'($urandom);
      b_in  = 16'($urandom);
      check($sformatf("busy_not_ready[%0d]", i), 64'({ready[1], ready[0]}), 64'd0);
      @(negedge clk);
    end
    start = 1'b0;

    // Abort a long operation with a one-edge reset partway through.
    issue(16'hFFFF, 16'hFFFF);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb0.delete();
    sb1.delete();
    rst_n = 1'b1;
    check_idle_after_reset("abort");
    issue(16'd2, 16'd3);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = rb & 16'h000F;
        1: rb = 16'h0000;
        2: rb = 16'hFFFF ^ (16'd1 << $urandom_range(0, 15));
        default: ;
      endcase
      issue(ra, rb);
    end

    w = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
